// File: rtl/cdb_arbiter_if.sv
// Bus bundle between the functional units and the common-data-bus arbiter:
// per-FU result inputs with back-pressure, and the CDB broadcast lanes.
interface cdb_arbiter_if #(
    parameter int NUM_FU    = 4,
    parameter int CDB_SIZE  = 2,
    parameter int ROB_DEPTH = 3
);
    logic [NUM_FU-1:0]                   fu_valid;
    logic [NUM_FU-1:0][ROB_DEPTH-1:0]    fu_rob;
    logic [NUM_FU-1:0][31:0]             fu_rd_v;
    logic [NUM_FU-1:0]                   fu_full;

    logic [CDB_SIZE-1:0]                 cdb_valid;
    logic [CDB_SIZE-1:0][ROB_DEPTH-1:0]  cdb_rob;
    logic [CDB_SIZE-1:0][31:0]           cdb_rd_v;

    // master: the FU/consumer side; slave: the arbiter
    modport master (
        output fu_valid, fu_rob, fu_rd_v,
        input  fu_full, cdb_valid, cdb_rob, cdb_rd_v
    );
    modport slave (
        input  fu_valid, fu_rob, fu_rd_v,
        output fu_full, cdb_valid, cdb_rob, cdb_rd_v
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one result FIFO per functional unit, drained
// round-robin onto CDB_SIZE broadcast lanes each cycle.
module cdb_arbiter #(
    parameter int NUM_FU     = 4,
    parameter int CDB_SIZE   = 2,
    parameter int ROB_DEPTH  = 3,
    parameter int FIFO_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    cdb_arbiter_if.slave  bus
);
    localparam int DEPTH   = 1 << FIFO_DEPTH;
    localparam int FU_W    = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int ENTRY_W = ROB_DEPTH + 32;

    logic [NUM_FU-1:0]  nonempty;
    logic [NUM_FU-1:0]  full;
    logic [NUM_FU-1:0]  push;
    logic [NUM_FU-1:0]  grant;
    logic [ENTRY_W-1:0] head_data [NUM_FU];

    logic [FU_W-1:0]    rr_ptr_reg;
    logic [FU_W-1:0]    rr_ptr_next;
    logic [CDB_SIZE-1:0] lane_valid;
    logic [FU_W-1:0]    lane_idx [CDB_SIZE];

    // Per-FU result FIFO; the head entry is read combinationally so a result
    // written at one edge is visible on the CDB in the very next cycle.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_FU; gi++) begin : g_fifo
            logic [ENTRY_W-1:0]    mem_reg [DEPTH];
            logic [FIFO_DEPTH-1:0] head_reg;
            logic [FIFO_DEPTH-1:0] tail_reg;
            logic [FIFO_DEPTH:0]   count_reg;

            assign nonempty[gi]    = (count_reg != '0);
            assign full[gi]        = (count_reg == (FIFO_DEPTH+1)'(DEPTH));
            assign push[gi]        = bus.fu_valid[gi] && !full[gi];
            assign bus.fu_full[gi] = full[gi];
            assign head_data[gi]   = mem_reg[head_reg];

            always_ff @(posedge clk) begin
                if (push[gi] && !flush && !rst) begin
                    mem_reg[tail_reg] <= {bus.fu_rob[gi], bus.fu_rd_v[gi]};
                end
            end

            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    head_reg  <= '0;
                    tail_reg  <= '0;
                    count_reg <= '0;
                end else begin
                    if (push[gi]) begin
                        tail_reg <= tail_reg + 1'b1;
                    end
                    if (grant[gi]) begin
                        head_reg <= head_reg + 1'b1;
                    end
                    case ({push[gi], grant[gi]})
                        2'b10:   count_reg <= count_reg + 1'b1;
                        2'b01:   count_reg <= count_reg - 1'b1;
                        default: count_reg <= count_reg;
                    endcase
                end
            end
        end
    endgenerate

    // Scan FIFOs starting at rr_ptr and pack grants densely from lane 0.
    always_comb begin
        int used;
        grant       = '0;
        lane_valid  = '0;
        rr_ptr_next = rr_ptr_reg;
        used        = 0;
        for (int k = 0; k < CDB_SIZE; k++) begin
            lane_idx[k] = '0;
        end
        for (int j = 0; j < NUM_FU; j++) begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (i == ((int'(rr_ptr_reg) + j) % NUM_FU)) begin
                    if (nonempty[i] && used < CDB_SIZE) begin
                        grant[i] = 1'b1;
                        for (int k = 0; k < CDB_SIZE; k++) begin
                            if (k == used) begin
                                lane_valid[k] = 1'b1;
                                lane_idx[k]   = FU_W'(i);
                            end
                        end
                        used        = used + 1;
                        rr_ptr_next = FU_W'((i + 1) % NUM_FU);
                    end
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < CDB_SIZE; k++) begin
            bus.cdb_valid[k] = lane_valid[k];
            bus.cdb_rob[k]   = '0;
            bus.cdb_rd_v[k]  = '0;
            if (lane_valid[k]) begin
                {bus.cdb_rob[k], bus.cdb_rd_v[k]} = head_data[lane_idx[k]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rr_ptr_reg <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: per-FU expected-result queues plus a round-robin
// reference scheduler, with directed scenarios followed by random traffic.
module tb_cdb_arbiter;
    localparam int NUM_FU     = 4;
    localparam int CDB_SIZE   = 2;
    localparam int ROB_DEPTH  = 3;
    localparam int FIFO_DEPTH = 2;
    localparam int DEPTH      = 1 << FIFO_DEPTH;

    logic clk;
    logic rst;
    logic flush;

    cdb_arbiter_if #(.NUM_FU(NUM_FU), .CDB_SIZE(CDB_SIZE), .ROB_DEPTH(ROB_DEPTH)) bus ();

    cdb_arbiter #(
        .NUM_FU(NUM_FU), .CDB_SIZE(CDB_SIZE),
        .ROB_DEPTH(ROB_DEPTH), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Scoreboard: expected {rob, value} entries per FU, and the expected rr pointer
    logic [34:0] mq [NUM_FU][$];
    int m_rr = 0;
    int lane_fu [CDB_SIZE];
    int lane_n;
    int nrr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sched();
        int i;
        lane_n = 0;
        nrr    = m_rr;
        for (int j = 0; j < NUM_FU; j++) begin
            i = (m_rr + j) % NUM_FU;
            if (mq[i].size() > 0 && lane_n < CDB_SIZE) begin
                lane_fu[lane_n] = i;
                lane_n++;
                nrr = (i + 1) % NUM_FU;
            end
        end
    endtask

    task automatic check_outputs();
        logic [34:0] e;
        sched();
        for (int k = 0; k < CDB_SIZE; k++) begin
            if (k < lane_n) begin
                e = mq[lane_fu[k]][0];
                check("lane_valid", 64'(bus.cdb_valid[k]), 64'(1));
                check("lane_rob",   64'(bus.cdb_rob[k]),   64'(e[34:32]));
                check("lane_data",  64'(bus.cdb_rd_v[k]),  64'(e[31:0]));
            end else begin
                check("idle_valid", 64'(bus.cdb_valid[k]), 64'(0));
                check("idle_rob",   64'(bus.cdb_rob[k]),   64'(0));
                check("idle_data",  64'(bus.cdb_rd_v[k]),  64'(0));
            end
        end
        for (int i = 0; i < NUM_FU; i++) begin
            check("fu_full", 64'(bus.fu_full[i]), 64'(mq[i].size() == DEPTH));
        end
    endtask

    // One clock: model the edge with the currently driven inputs, then compare.
    task automatic tick();
        logic [NUM_FU-1:0] v;
        logic [2:0]  rob [NUM_FU];
        logic [31:0] d   [NUM_FU];
        int          sz  [NUM_FU];
        logic        r, f;
        v = bus.fu_valid;
        r = rst;
        f = flush;
        for (int i = 0; i < NUM_FU; i++) begin
            rob[i] = bus.fu_rob[i];
            d[i]   = bus.fu_rd_v[i];
            sz[i]  = mq[i].size();
        end
        sched();
        @(posedge clk);
        if (r || f) begin
            for (int i = 0; i < NUM_FU; i++) mq[i].delete();
            m_rr = 0;
        end else begin
            for (int k = 0; k < lane_n; k++) void'(mq[lane_fu[k]].pop_front());
            for (int i = 0; i < NUM_FU; i++) begin
                if (v[i] && sz[i] < DEPTH) mq[i].push_back({rob[i], d[i]});
            end
            if (lane_n > 0) m_rr = nrr;
        end
        #1;
        check_outputs();
    endtask

    task automatic set_fu(input int i, input logic [2:0] rob, input logic [31:0] d);
        bus.fu_valid[i] = 1'b1;
        bus.fu_rob[i]   = rob;
        bus.fu_rd_v[i]  = d;
    endtask

    task automatic idle();
        bus.fu_valid = '0;
        flush        = 1'b0;
    endtask

    task automatic do_flush();
        bus.fu_valid = '0;
        flush        = 1'b1;
        tick();
        flush        = 1'b0;
    endtask

    logic saw_full3;

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        bus.fu_valid = '0;
        bus.fu_rob   = '0;
        bus.fu_rd_v  = '0;

        // Reset held two cycles with every FU pulsing
        for (int i = 0; i < NUM_FU; i++) set_fu(i, 3'(i), 32'h1000 + 32'(i));
        tick();
        tick();
        rst = 1'b0;
        idle();
        tick();
        check("rst_cdb_valid", 64'(bus.cdb_valid), 64'(0));
        check("rst_fu_full",   64'(bus.fu_full),   64'(0));

        // Single result latency
        set_fu(1, 3'd5, 32'hDEADBEEF);
        tick();
        idle();
        check("lat_valid", 64'(bus.cdb_valid), 64'(2'b01));
        check("lat_rob",   64'(bus.cdb_rob[0]), 64'(5));
        check("lat_data",  64'(bus.cdb_rd_v[0]), 64'(32'hDEADBEEF));
        tick();
        check("lat_idle",  64'(bus.cdb_valid), 64'(0));

        // Round-robin from rr_ptr = 0
        do_flush();
        set_fu(0, 3'd1, 32'h100);
        set_fu(1, 3'd2, 32'h101);
        set_fu(2, 3'd3, 32'h102);
        tick();
        idle();
        check("rr1_valid", 64'(bus.cdb_valid), 64'(2'b11));
        check("rr1_lane0", 64'(bus.cdb_rd_v[0]), 64'(32'h100));
        check("rr1_lane1", 64'(bus.cdb_rd_v[1]), 64'(32'h101));
        tick();
        check("rr2_valid", 64'(bus.cdb_valid), 64'(2'b01));
        check("rr2_lane0", 64'(bus.cdb_rd_v[0]), 64'(32'h102));
        tick();
        // rr_ptr should now be 3: FU3 must win lane 0 over FU0
        set_fu(0, 3'd1, 32'h200);
        set_fu(3, 3'd4, 32'h203);
        tick();
        idle();
        check("rr3_lane0", 64'(bus.cdb_rob[0]), 64'(4));
        check("rr3_lane1", 64'(bus.cdb_rob[1]), 64'(1));
        tick();

        // Back-pressure: every FU pushes each cycle, faster than the CDB drains
        do_flush();
        saw_full3 = 1'b0;
        for (int c = 0; c < 14; c++) begin
            for (int i = 0; i < NUM_FU; i++) set_fu(i, 3'(c), {8'(i), 24'(c)});
            tick();
            if (bus.fu_full[3]) saw_full3 = 1'b1;
        end
        idle();
        check("bp_full3_seen", 64'(saw_full3), 64'(1));
        for (int c = 0; c < 12; c++) tick();
        check("bp_drained", 64'(bus.cdb_valid), 64'(0));

        // Simultaneous push and pop on FIFO 2
        do_flush();
        set_fu(0, 3'd0, 32'h500);
        set_fu(1, 3'd1, 32'h501);
        set_fu(2, 3'd6, 32'hA);
        tick();
        idle();
        set_fu(2, 3'd6, 32'hB);
        tick();
        idle();
        check("pp_a", 64'(bus.cdb_rd_v[0]), 64'(32'hA));
        set_fu(2, 3'd6, 32'hC);
        tick();
        idle();
        check("pp_b", 64'(bus.cdb_rd_v[0]), 64'(32'hB));
        tick();
        check("pp_c", 64'(bus.cdb_rd_v[0]), 64'(32'hC));
        tick();
        check("pp_idle", 64'(bus.cdb_valid), 64'(0));

        // Flush with a concurrent push
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 3; i++) set_fu(i, 3'(i), 32'h700 + 32'(c * 4 + i));
            tick();
        end
        idle();
        set_fu(0, 3'd7, 32'hF1F1F1F1);
        flush = 1'b1;
        tick();
        idle();
        check("fl_valid", 64'(bus.cdb_valid), 64'(0));
        check("fl_full",  64'(bus.fu_full),   64'(0));
        for (int c = 0; c < 3; c++) begin
            tick();
            check("fl_quiet", 64'(bus.cdb_valid), 64'(0));
        end

        // Random traffic with occasional flush and reset
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NUM_FU; i++) begin
                bus.fu_valid[i] = ($urandom_range(0, 2) != 0);
                bus.fu_rob[i]   = 3'($urandom);
                bus.fu_rd_v[i]  = $urandom;
            end
            flush = ($urandom_range(0, 40) == 0);
            rst   = ($urandom_range(0, 120) == 0);
            tick();
        end
        rst = 1'b0;
        idle();
        for (int c = 0; c < 10; c++) tick();
        check("end_idle", 64'(bus.cdb_valid), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
